// File: rtl/t5_mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : t5_mem_arb_pkg
//  Description : Shared types and constants for the t5 memory arbiter.
//                Holds the arbiter state encoding and the default datapath
//                width.
//  Revision    : 1.0 - initial release
// ============================================================================
package t5_mem_arb_pkg;

    // Default data/address width; word addresses are [XLEN-1:2].
    localparam int c_XLEN = 32;

    // Arbiter states: idle, or owning the memory bus for fetch or data.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_IBUS = 2'd1,
        ST_DBUS = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/t5_mem_arb_if.sv
`default_nettype none
// ============================================================================
//  Module      : t5_mem_arb_if
//  Description : Bundle of the three Wishbone-classic buses around the
//                arbiter: instruction fetch (iwb_*), data (dwb_*) and the
//                shared memory master (mwb_*).
//                modport slave  : arbiter view (serves iwb/dwb, drives mwb)
//                modport master : environment view (CPU ports and memory)
//  Revision    : 1.0 - initial release
// ============================================================================
interface t5_mem_arb_if
    import t5_mem_arb_pkg::*;
#(
    parameter int XLEN = c_XLEN
);
    // Instruction fetch port
    logic              iwb_stb;
    logic [XLEN-3:0]   iwb_adr;
    logic [XLEN-1:0]   iwb_dat;
    logic              iwb_ack;
    logic              iwb_err;
    // Data port
    logic              dwb_stb;
    logic              dwb_wre;
    logic [XLEN-3:0]   dwb_adr;
    logic [3:0]        dwb_sel;
    logic [XLEN-1:0]   dwb_dto;
    logic [XLEN-1:0]   dwb_dti;
    logic              dwb_ack;
    logic              dwb_err;
    // Memory master
    logic              mwb_stb;
    logic              mwb_wre;
    logic [XLEN-3:0]   mwb_adr;
    logic [3:0]        mwb_sel;
    logic [XLEN-1:0]   mwb_dto;
    logic [XLEN-1:0]   mwb_dti;
    logic              mwb_ack;

    modport slave (
        input  iwb_stb, iwb_adr,
        output iwb_dat, iwb_ack, iwb_err,
        input  dwb_stb, dwb_wre, dwb_adr, dwb_sel, dwb_dto,
        output dwb_dti, dwb_ack, dwb_err,
        output mwb_stb, mwb_wre, mwb_adr, mwb_sel, mwb_dto,
        input  mwb_dti, mwb_ack
    );

    modport master (
        output iwb_stb, iwb_adr,
        input  iwb_dat, iwb_ack, iwb_err,
        output dwb_stb, dwb_wre, dwb_adr, dwb_sel, dwb_dto,
        input  dwb_dti, dwb_ack, dwb_err,
        input  mwb_stb, mwb_wre, mwb_adr, mwb_sel, mwb_dto,
        output mwb_dti, mwb_ack
    );

endinterface
`default_nettype wire

// File: rtl/t5_mem_arb.sv
`default_nettype none
// ============================================================================
//  Module      : t5_mem_arb
//  Description : Arbitrates the t5_cpu fetch and data ports onto a single
//                Wishbone-classic memory master. Data wins by default, but
//                after DMAX consecutive data grants with a fetch waiting the
//                fetch is served. A watchdog aborts a memory cycle that sees
//                no mwb_ack and reports an error pulse to the requester.
//  Ports       : sys_clk  - clock, rising edge
//                sys_rst  - asynchronous reset, active low
//                sys_ena  - 1 allows new grants; in-flight cycles always finish
//                bus      - iwb/dwb/mwb buses (t5_mem_arb_if.slave)
//  Parameters  : XLEN  - data width (must match the interface)
//                DMAX  - max consecutive data grants while a fetch waits
//                TMO_W - watchdog width; abort after 2**TMO_W-1 bus cycles
//  Revision    : 1.0 - initial release
// ============================================================================
module t5_mem_arb
    import t5_mem_arb_pkg::*;
#(
    parameter int XLEN  = c_XLEN,
    parameter int DMAX  = 4,
    parameter int TMO_W = 8
) (
    input  wire logic     sys_clk,
    input  wire logic     sys_rst,
    input  wire logic     sys_ena,
    t5_mem_arb_if.slave   bus
);

    localparam int               c_SCW      = $clog2(DMAX + 1);
    // Expiry is detected one count early so that the abort lands on the edge
    // where the counter would reach all-ones (2**TMO_W-1 cycles of mwb_stb).
    localparam logic [TMO_W-1:0] c_TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_SCW-1:0]   r_scnt;
    logic [TMO_W-1:0]   r_tcnt;

    logic               r_mwb_stb;
    logic               r_mwb_wre;
    logic [XLEN-3:0]    r_mwb_adr;
    logic [3:0]         r_mwb_sel;
    logic [XLEN-1:0]    r_mwb_dto;
    logic               r_iwb_ack;
    logic               r_iwb_err;
    logic [XLEN-1:0]    r_iwb_dat;
    logic               r_dwb_ack;
    logic               r_dwb_err;
    logic [XLEN-1:0]    r_dwb_dti;

    logic               w_i_req;
    logic               w_d_req;
    logic               w_pick_d;
    logic               w_grant_i;
    logic               w_grant_d;
    logic               w_done_ack;
    logic               w_done_tmo;

    // A requester acked/errored this cycle still holds stb; it is not a new
    // request and must not be granted again.
    assign w_i_req  = bus.iwb_stb & ~(r_iwb_ack | r_iwb_err);
    assign w_d_req  = bus.dwb_stb & ~(r_dwb_ack | r_dwb_err);
    assign w_pick_d = w_d_req & (~w_i_req | (r_scnt < c_SCW'(DMAX)));

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_i   = 1'b0;
        w_grant_d   = 1'b0;
        w_done_ack  = 1'b0;
        w_done_tmo  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (sys_ena && (w_i_req || w_d_req)) begin
                    if (w_pick_d) begin
                        w_grant_d   = 1'b1;
                        w_state_nxt = ST_DBUS;
                    end else begin
                        w_grant_i   = 1'b1;
                        w_state_nxt = ST_IBUS;
                    end
                end
            end
            ST_IBUS, ST_DBUS: begin
                // An ack arriving on the expiry cycle completes normally.
                if (bus.mwb_ack) begin
                    w_done_ack  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (r_tcnt == c_TMO_LAST) begin
                    w_done_tmo  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_scnt    <= '0;
            r_tcnt    <= '0;
            r_mwb_stb <= 1'b0;
            r_mwb_wre <= 1'b0;
            r_mwb_adr <= '0;
            r_mwb_sel <= '0;
            r_mwb_dto <= '0;
            r_iwb_ack <= 1'b0;
            r_iwb_err <= 1'b0;
            r_iwb_dat <= '0;
            r_dwb_ack <= 1'b0;
            r_dwb_err <= 1'b0;
            r_dwb_dti <= '0;
        end else begin
            // Starvation count: data grants made while a fetch is waiting.
            if (w_grant_i || !w_i_req) begin
                r_scnt <= '0;
            end else if (w_grant_d && (r_scnt != c_SCW'(DMAX))) begin
                r_scnt <= r_scnt + 1'b1;
            end

            if (w_grant_i || w_grant_d) begin
                r_tcnt <= '0;
            end else if (r_state != ST_IDLE) begin
                r_tcnt <= r_tcnt + 1'b1;
            end

            if (w_grant_d) begin
                r_mwb_stb <= 1'b1;
                r_mwb_wre <= bus.dwb_wre;
                r_mwb_adr <= bus.dwb_adr;
                r_mwb_sel <= bus.dwb_sel;
                r_mwb_dto <= bus.dwb_dto;
            end else if (w_grant_i) begin
                r_mwb_stb <= 1'b1;
                r_mwb_wre <= 1'b0;
                r_mwb_adr <= bus.iwb_adr;
                r_mwb_sel <= 4'hF;
                r_mwb_dto <= '0;
            end else if (w_done_ack || w_done_tmo) begin
                r_mwb_stb <= 1'b0;
            end

            r_iwb_ack <= w_done_ack && (r_state == ST_IBUS);
            r_iwb_err <= w_done_tmo && (r_state == ST_IBUS);
            r_dwb_ack <= w_done_ack && (r_state == ST_DBUS);
            r_dwb_err <= w_done_tmo && (r_state == ST_DBUS);

            // Read data is captured on completion and held until the next one;
            // an aborted cycle returns zero.
            if ((w_done_ack || w_done_tmo) && (r_state == ST_IBUS)) begin
                r_iwb_dat <= w_done_ack ? bus.mwb_dti : '0;
            end
            if ((w_done_ack || w_done_tmo) && (r_state == ST_DBUS)) begin
                r_dwb_dti <= w_done_ack ? bus.mwb_dti : '0;
            end
        end
    end

    assign bus.mwb_stb = r_mwb_stb;
    assign bus.mwb_wre = r_mwb_wre;
    assign bus.mwb_adr = r_mwb_adr;
    assign bus.mwb_sel = r_mwb_sel;
    assign bus.mwb_dto = r_mwb_dto;
    assign bus.iwb_ack = r_iwb_ack;
    assign bus.iwb_err = r_iwb_err;
    assign bus.iwb_dat = r_iwb_dat;
    assign bus.dwb_ack = r_dwb_ack;
    assign bus.dwb_err = r_dwb_err;
    assign bus.dwb_dti = r_dwb_dti;

endmodule
`default_nettype wire

// File: tb/tb_t5_mem_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_t5_mem_arb
//  Description : Self-checking bench for t5_mem_arb. Two requesters and a
//                word memory are modelled at transaction level: each access
//                is given a wait count, and its end cycle follows from
//                grant + 1 + min(wait+1, 2**TMO_W-1).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_t5_mem_arb;
    import t5_mem_arb_pkg::*;

    localparam int XLEN    = 32;
    localparam int DMAX    = 4;
    localparam int TMO_W   = 4;
    localparam int TMO_CYC = (1 << TMO_W) - 1;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    logic sys_ena = 1'b0;

    t5_mem_arb_if #(.XLEN(XLEN)) bus ();

    t5_mem_arb #(.XLEN(XLEN), .DMAX(DMAX), .TMO_W(TMO_W)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .sys_ena (sys_ena),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [31:0] mem [256];

    // Requesters
    bit          ipend, dpend;
    logic [29:0] i_adr, d_adr;
    logic        d_wre;
    logic [3:0]  d_sel;
    logic [31:0] d_dto;

    // Stimulus knobs
    int p_i, p_d, p_ena, p_stray, p_rst, force_w;
    bit ena_skip_fin, rst_req;

    // Reference model
    bit          m_busy;
    int          m_owner;      // 0 = fetch, 1 = data
    int          m_end, m_ackc;
    int          dwait;
    logic [29:0] m_adr;
    logic        m_wre;
    logic [3:0]  m_sel;
    logic [31:0] m_dto;
    bit          e_mstb, e_mwre, e_iack, e_ierr, e_dack, e_derr;
    logic [29:0] e_madr;
    logic [3:0]  e_msel;
    logic [31:0] e_mdto, e_idat, e_ddti;

    // Grant-order log
    bit          log_en;
    int          log_n;
    logic [9:0]  log_bits;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int pick_wait();
        int r;
        if (force_w >= 0) return force_w;
        r = int'($urandom_range(15));
        if (r < 11)  return int'($urandom_range(3));
        if (r < 13)  return int'($urandom_range(13, 4));
        if (r == 13) return 14;
        return 99;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_ackc = -1; m_end = -1; dwait = 0; m_owner = 0;
        e_mstb = 0; e_mwre = 0; e_madr = '0; e_msel = '0; e_mdto = '0;
        e_iack = 0; e_ierr = 0; e_idat = '0;
        e_dack = 0; e_derr = 0; e_ddti = '0;
    endtask

    // One clock cycle: check this cycle's outputs, drive this cycle's inputs,
    // and predict the outputs of the next cycle.
    task automatic step();
        bit          i_fin, d_fin, idle, i_req, d_req, gi, gd, mack, busy_n;
        bit          n_iack, n_ierr, n_dack, n_derr;
        logic [31:0] rd;
        int          w;
        @(negedge sys_clk);
        chk("mwb_stb", 32'(bus.mwb_stb), 32'(e_mstb));
        chk("mwb_wre", 32'(bus.mwb_wre), 32'(e_mwre));
        chk("mwb_adr", 32'(bus.mwb_adr), 32'(e_madr));
        chk("mwb_sel", 32'(bus.mwb_sel), 32'(e_msel));
        chk("mwb_dto", bus.mwb_dto, e_mdto);
        chk("iwb_ack", 32'(bus.iwb_ack), 32'(e_iack));
        chk("iwb_err", 32'(bus.iwb_err), 32'(e_ierr));
        chk("iwb_dat", bus.iwb_dat, e_idat);
        chk("dwb_ack", 32'(bus.dwb_ack), 32'(e_dack));
        chk("dwb_err", 32'(bus.dwb_err), 32'(e_derr));
        chk("dwb_dti", bus.dwb_dti, e_ddti);
        if (log_en && log_n < 10 && (bus.iwb_ack || bus.dwb_ack)) begin
            log_bits = {log_bits[8:0], bus.dwb_ack};
            log_n++;
        end

        i_fin = e_iack | e_ierr;
        d_fin = e_dack | e_derr;
        if (!sys_rst) sys_rst = 1'b1;

        if (rst_req || (int'($urandom_range(999)) < p_rst)) begin
            rst_req = 0;
            sys_rst = 1'b0;
            bus.mwb_ack = 1'b0;
            #1;
            chk("rst_mwb_stb", 32'(bus.mwb_stb), 32'd0);
            chk("rst_mwb_adr", 32'(bus.mwb_adr), 32'd0);
            chk("rst_mwb_sel", 32'(bus.mwb_sel), 32'd0);
            chk("rst_iwb_ack", 32'(bus.iwb_ack), 32'd0);
            chk("rst_iwb_dat", bus.iwb_dat, 32'd0);
            chk("rst_dwb_ack", 32'(bus.dwb_ack), 32'd0);
            chk("rst_dwb_dti", bus.dwb_dti, 32'd0);
            model_reset();
            if (i_fin) ipend = 0;
            if (d_fin) dpend = 0;
            cyc++;
            return;
        end

        idle = !m_busy;
        if (!ipend && int'($urandom_range(99)) < p_i) begin
            ipend = 1; i_adr = 30'($urandom);
        end
        if (!dpend && int'($urandom_range(99)) < p_d) begin
            dpend = 1; d_adr = 30'($urandom); d_wre = 1'($urandom_range(1));
            d_sel = 4'($urandom_range(15, 1)); d_dto = $urandom;
        end
        bus.iwb_stb = ipend;  bus.iwb_adr = i_adr;
        bus.dwb_stb = dpend;  bus.dwb_adr = d_adr;  bus.dwb_wre = d_wre;
        bus.dwb_sel = d_sel;  bus.dwb_dto = d_dto;
        sys_ena = (int'($urandom_range(99)) < p_ena) && !(ena_skip_fin && (i_fin || d_fin));

        mack = m_busy && (cyc == m_ackc);
        rd   = mem[m_adr[7:0]];
        if (mack) begin
            bus.mwb_ack = 1'b1;
            bus.mwb_dti = rd;
            if (m_wre) begin
                for (int b = 0; b < 4; b++)
                    if (m_sel[b]) mem[m_adr[7:0]][8*b +: 8] = m_dto[8*b +: 8];
            end
        end else begin
            bus.mwb_ack = idle && (int'($urandom_range(99)) < p_stray);
            bus.mwb_dti = $urandom;
        end

        n_iack = 0; n_ierr = 0; n_dack = 0; n_derr = 0;
        busy_n = m_busy;
        if (m_busy && (cyc + 1 == m_end)) begin
            busy_n = 0;
            if (m_owner == 0) begin
                if (m_ackc < 0) begin n_ierr = 1; e_idat = '0; end
                else            begin n_iack = 1; e_idat = rd;  end
            end else begin
                if (m_ackc < 0) begin n_derr = 1; e_ddti = '0; end
                else            begin n_dack = 1; e_ddti = rd;  end
            end
        end

        i_req = ipend && !i_fin;
        d_req = dpend && !d_fin;
        gi = 0; gd = 0;
        if (idle && sys_ena && (i_req || d_req)) begin
            if (d_req && (!i_req || dwait < DMAX)) gd = 1;
            else                                   gi = 1;
        end
        if (gi || !i_req)  dwait = 0;
        else if (gd)       dwait = (dwait < DMAX) ? dwait + 1 : DMAX;

        if (gi || gd) begin
            w       = pick_wait();
            m_owner = gd ? 1 : 0;
            busy_n  = 1;
            m_end   = cyc + 1 + ((w + 1 < TMO_CYC) ? w + 1 : TMO_CYC);
            m_ackc  = (w + 1 <= TMO_CYC) ? cyc + 1 + w : -1;
            m_adr   = gd ? d_adr : i_adr;
            m_wre   = gd ? d_wre : 1'b0;
            m_sel   = gd ? d_sel : 4'hF;
            m_dto   = gd ? d_dto : 32'd0;
            e_madr  = m_adr; e_mwre = m_wre; e_msel = m_sel; e_mdto = m_dto;
        end
        m_busy = busy_n;
        e_mstb = busy_n;
        e_iack = n_iack; e_ierr = n_ierr; e_dack = n_dack; e_derr = n_derr;
        if (i_fin) ipend = 0;
        if (d_fin) dpend = 0;
        cyc++;
    endtask

    task automatic drain();
        p_i = 0; p_d = 0; p_ena = 100; p_stray = 0; p_rst = 0; ena_skip_fin = 0;
        repeat (20) step();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        ipend = 0; dpend = 0; i_adr = '0; d_adr = '0; d_wre = 0; d_sel = '0; d_dto = '0;
        m_adr = '0; m_wre = 0; m_sel = '0; m_dto = '0;
        log_en = 0; log_n = 0; log_bits = '0; rst_req = 0;
        bus.iwb_stb = 0; bus.iwb_adr = '0; bus.dwb_stb = 0; bus.dwb_wre = 0;
        bus.dwb_adr = '0; bus.dwb_sel = '0; bus.dwb_dto = '0;
        bus.mwb_ack = 0; bus.mwb_dti = '0;
        model_reset();
        p_i = 0; p_d = 0; p_ena = 100; p_stray = 0; p_rst = 0; force_w = 0; ena_skip_fin = 0;
        #1 sys_rst = 1'b0;

        // Reset values are checked on the first step, which also releases reset.
        step();
        step();

        // Zero-wait fetch from word 0x10.
        ipend = 1; i_adr = 30'h10;
        repeat (4) step();
        chk("fetch_dat", bus.iwb_dat, mem[8'h10]);

        // Both requesters held; grants only outside ack cycles -> D,D,D,D,I,...
        drain();
        force_w = 0; p_i = 100; p_d = 100; ena_skip_fin = 1;
        log_en = 1;
        repeat (31) step();
        log_en = 0;
        chk("starve_order", 32'(log_bits), 32'(10'b1111011110));
        drain();

        // Free-running arbitration with both held (ack-mask alternation).
        p_i = 100; p_d = 100;
        repeat (24) step();
        drain();

        // Data write with two wait states.
        force_w = 2;
        dpend = 1; d_wre = 1; d_adr = 30'h20; d_sel = 4'h3; d_dto = 32'hA5A5_1234;
        repeat (6) step();

        // Memory never acks: watchdog error, then a normal access.
        force_w = 99;
        dpend = 1; d_wre = 0; d_adr = 30'h44; d_sel = 4'hF;
        repeat (18) step();
        force_w = 14;
        dpend = 1; d_adr = 30'h45;
        repeat (18) step();
        force_w = 0;
        ipend = 1; i_adr = 30'h3;
        repeat (4) step();

        // sys_ena drops during a data access.
        force_w = 3;
        dpend = 1; d_wre = 1; d_adr = 30'h7; d_sel = 4'h9; d_dto = 32'h1357_9BDF;
        step();
        p_ena = 0;
        ipend = 1; i_adr = 30'h8;
        repeat (10) step();
        p_ena = 100;
        repeat (6) step();

        // Reset while a fetch is waiting on memory; fetch is reissued.
        force_w = 8;
        ipend = 1; i_adr = 30'h11;
        repeat (4) step();
        rst_req = 1;
        step();
        force_w = 0;
        repeat (6) step();

        // Randomised traffic with stray acks, sys_ena gaps and occasional resets.
        force_w = -1; p_i = 40; p_d = 40; p_ena = 85; p_stray = 5; p_rst = 2;
        repeat (3000) step();
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
